// File: rtl/series_adder_bitserial.sv
// Bit-serial adder for M operand channels: presents one bit-plane per cycle LSB-first,
// accumulates popcounts with a small signed carry and emits an exact W+log2(M)-bit sum.
module series_adder_bitserial #(
  parameter int unsigned M = 8,
  parameter int unsigned W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [M*W-1:0]          data_i,
  input  logic                    signed_i,
  output logic [M-1:0]            plane_o,
  output logic                    plane_vld,
  output logic                    plane_last,
  output logic [W+$clog2(M)-1:0]  result_o,
  output logic                    result_vld,
  input  logic                    result_rdy,
  output logic                    busy
);

  localparam int unsigned L  = $clog2(M);
  localparam int unsigned RW = W + L;
  localparam int unsigned CW = L + 2;
  localparam int unsigned KW = $clog2(W) + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic signed [CW-1:0] carry_q, carry_d;
  logic [RW-1:0]        res_q, res_d;
  logic [M*W-1:0]       data_q, data_d;
  logic                 sgn_q, sgn_d;
  logic                 vld_q, vld_d;

  logic [M-1:0]         plane;
  logic [L:0]           pc;
  logic signed [CW-1:0] pc_ext;
  logic signed [CW-1:0] t;
  logic                 last_plane;

  // The operand register shifts right once per plane, so bit c*W always holds
  // bit k of channel c while k < W.
  always_comb begin
    plane = '0;
    pc    = '0;
    for (int c = 0; c < int'(M); c++) begin
      plane[c] = data_q[c*W];
      pc       = pc + {{L{1'b0}}, plane[c]};
    end
  end

  assign last_plane = (k_q == KW'(W - 1));
  assign pc_ext     = $signed({1'b0, pc});
  // The MSB plane carries weight -2^(W-1) for two's complement operands.
  assign t          = (sgn_q && last_plane) ? (carry_q - pc_ext) : (carry_q + pc_ext);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    res_d   = res_q;
    data_d  = data_q;
    sgn_d   = sgn_q;
    vld_d   = vld_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = data_i;
          sgn_d   = signed_i;
          carry_d = '0;
          res_d   = '0;
          k_d     = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        res_d   = {t[0], res_q[RW-1:1]};
        carry_d = t >>> 1;
        data_d  = data_q >> 1;
        if (last_plane) begin
          k_d     = '0;
          state_d = StFlush;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StFlush: begin
        res_d   = {carry_q[0], res_q[RW-1:1]};
        carry_d = carry_q >>> 1;
        if (k_q == KW'(L - 1)) begin
          k_d     = '0;
          state_d = StDone;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDone: begin
        // First DONE cycle only raises result_vld; the handshake is honoured after that.
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (result_rdy) begin
          vld_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      carry_q <= '0;
      res_q   <= '0;
      data_q  <= '0;
      sgn_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      data_q  <= data_d;
      sgn_q   <= sgn_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign plane_vld  = (state_q == StShift);
  assign plane_o    = plane_vld ? plane : '0;
  assign plane_last = plane_vld && last_plane;
  assign result_o   = res_q;
  assign result_vld = vld_q;

endmodule

// File: tb/tb_series_adder_bitserial.sv
// Self-checking bench for series_adder_bitserial: directed vector table, handshake and reset
// sequences, and randomized bundles against an arithmetic sum model.
module tb_series_adder_bitserial;

  localparam int MA = 8;
  localparam int WA = 32;
  localparam int LA = 3;
  localparam int RWA = WA + LA;
  localparam int MB = 3;
  localparam int WB = 4;
  localparam int RWB = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               a_in_valid, a_in_ready, a_signed, a_plane_vld, a_plane_last;
  logic               a_result_vld, a_result_rdy, a_busy;
  logic [MA*WA-1:0]   a_data;
  logic [MA-1:0]      a_plane;
  logic [RWA-1:0]     a_result;

  logic               b_in_valid, b_in_ready, b_signed, b_plane_vld, b_plane_last;
  logic               b_result_vld, b_result_rdy, b_busy;
  logic [MB*WB-1:0]   b_data;
  logic [MB-1:0]      b_plane;
  logic [RWB-1:0]     b_result;

  series_adder_bitserial #(.M(MA), .W(WA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .data_i(a_data),
    .signed_i(a_signed), .plane_o(a_plane), .plane_vld(a_plane_vld), .plane_last(a_plane_last),
    .result_o(a_result), .result_vld(a_result_vld), .result_rdy(a_result_rdy), .busy(a_busy)
  );

  series_adder_bitserial #(.M(MB), .W(WB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .data_i(b_data),
    .signed_i(b_signed), .plane_o(b_plane), .plane_vld(b_plane_vld), .plane_last(b_plane_last),
    .result_o(b_result), .result_vld(b_result_vld), .result_rdy(b_result_rdy), .busy(b_busy)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Exact integer sum of mm channels of ww bits, reduced to rw bits.
  function automatic logic [63:0] model(input logic [255:0] d, input logic s, input int mm,
                                        input int ww, input int rw);
    longint sum = 0;
    for (int c = 0; c < mm; c++) begin
      longint v = 0;
      for (int j = 0; j < ww; j++) if (d[c*ww+j]) v += (longint'(1) << j);
      if (s && d[c*ww+ww-1]) v -= (longint'(1) << ww);
      sum += v;
    end
    return 64'(sum) & ((64'(1) << rw) - 1);
  endfunction

  function automatic logic [255:0] rand_bundle();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One full operation on DUT A; hold = DONE cycles with result_rdy low and in_valid high.
  task automatic run_a(input logic [255:0] d, input logic s, input logic [63:0] exp,
                       input logic pre_rdy, input int hold, input string tag);
    int lat = -1;
    int np = 0;
    int lastk = -1;
    int pbad = 0;
    logic [RWA-1:0] first;
    int unstable = 0;
    @(negedge clk);
    chk({tag, " in_ready idle"}, 64'(a_in_ready), 64'd1);
    a_data = d;
    a_signed = s;
    a_in_valid = 1'b1;
    a_result_rdy = pre_rdy;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    a_data = rand_bundle();
    a_signed = ~s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_plane_vld) begin
        for (int c = 0; c < MA; c++) if (a_plane[c] !== d[c*WA+np]) pbad++;
        if (a_plane_last) lastk = i;
        np++;
      end
      if (a_result_vld) begin
        lat = i;
        break;
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'(WA + LA + 1));
    chk({tag, " plane count"}, 64'(np), 64'(WA));
    chk({tag, " plane_last pos"}, 64'(lastk), 64'(WA - 1));
    chk({tag, " plane bits bad"}, 64'(pbad), 64'd0);
    chk({tag, " result"}, 64'(a_result), exp);
    first = a_result;
    if (!pre_rdy) begin
      for (int h = 0; h < hold; h++) begin
        a_in_valid = 1'b1;
        a_data = rand_bundle();
        @(negedge clk);
        if (!a_result_vld || a_result !== first || a_in_ready) unstable++;
      end
      a_in_valid = 1'b0;
      if (hold > 0) chk({tag, " DONE hold unstable"}, 64'(unstable), 64'd0);
      a_result_rdy = 1'b1;
      @(negedge clk);
    end else begin
      @(negedge clk);
    end
    a_result_rdy = 1'b0;
    chk({tag, " vld after handshake"}, 64'(a_result_vld), 64'd0);
    chk({tag, " idle after handshake"}, 64'(a_in_ready), 64'd1);
  endtask

  task automatic run_b(input logic [11:0] d, input logic s, input logic [63:0] exp,
                       input string tag);
    int lat = -1;
    @(negedge clk);
    b_data = d;
    b_signed = s;
    b_in_valid = 1'b1;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_data = 12'(~d);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_result_vld) begin
        lat = i;
        break;
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'd7);
    chk({tag, " result"}, 64'(b_result), exp);
    b_result_rdy = 1'b1;
    @(negedge clk);
    b_result_rdy = 1'b0;
    chk({tag, " vld low"}, 64'(b_result_vld), 64'd0);
  endtask

  typedef struct {
    logic [255:0] d;
    logic         s;
    logic [63:0]  exp;
    string        name;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [255:0] d;
    logic s;
    int saw_vld;

    for (int c = 0; c < MA; c++) vecs[0].d[c*32 +: 32] = 32'(c + 1);
    vecs[0].s = 1'b0; vecs[0].exp = 64'h24;        vecs[0].name = "words1to8";
    vecs[1].d = '1;
    vecs[1].s = 1'b0; vecs[1].exp = 64'h7FFFFFFF8; vecs[1].name = "all_ones_u";
    vecs[2].d = '0; vecs[2].d[31:0] = 32'hFFFFFFFF; vecs[2].d[63:32] = 32'h3;
    vecs[2].s = 1'b1; vecs[2].exp = 64'h2;         vecs[2].name = "mixed_s";
    vecs[3].d = vecs[2].d;
    vecs[3].s = 1'b0; vecs[3].exp = 64'h100000002; vecs[3].name = "mixed_u";
    for (int c = 0; c < MA; c++) vecs[4].d[c*32 +: 32] = 32'h80000000;
    vecs[4].s = 1'b1; vecs[4].exp = 64'h400000000; vecs[4].name = "all_min_s";
    vecs[5].d = '0;
    vecs[5].s = 1'b1; vecs[5].exp = 64'h0;         vecs[5].name = "zeros_s";

    a_in_valid = 0; a_signed = 0; a_data = '0; a_result_rdy = 0;
    b_in_valid = 0; b_signed = 0; b_data = '0; b_result_rdy = 0;

    #1;
    chk("reset in_ready", 64'(a_in_ready), 64'd1);
    chk("reset busy", 64'(a_busy), 64'd0);
    chk("reset result_vld", 64'(a_result_vld), 64'd0);
    chk("reset result_o", 64'(a_result), 64'd0);
    chk("reset plane_vld", 64'(a_plane_vld), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", 64'(a_in_ready), 64'd1);

    foreach (vecs[i]) run_a(vecs[i].d, vecs[i].s, vecs[i].exp, 1'b0, 0, vecs[i].name);

    // Stall in DONE with a competing bundle offered, then accept that bundle.
    run_a(vecs[0].d, 1'b0, 64'h24, 1'b0, 10, "stall");
    run_a(vecs[1].d, 1'b0, 64'h7FFFFFFF8, 1'b0, 0, "after_stall");
    run_a(vecs[2].d, 1'b1, 64'h2, 1'b1, 0, "pre_rdy");

    // Reset at plane k=10.
    @(negedge clk);
    a_data = rand_bundle();
    a_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid-op busy", 64'(a_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 64'(a_in_ready), 64'd1);
    chk("midrst busy", 64'(a_busy), 64'd0);
    chk("midrst plane_vld", 64'(a_plane_vld), 64'd0);
    chk("midrst plane_last", 64'(a_plane_last), 64'd0);
    chk("midrst plane_o", 64'(a_plane), 64'd0);
    chk("midrst result_vld", 64'(a_result_vld), 64'd0);
    chk("midrst result_o", 64'(a_result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_vld = 0;
    repeat (50) begin
      @(negedge clk);
      if (a_result_vld) saw_vld++;
    end
    chk("no vld after reset", 64'(saw_vld), 64'd0);
    run_a(vecs[0].d, 1'b0, 64'h24, 1'b0, 0, "after_rst");

    run_b(12'h888, 1'b1, 64'h28, "b_min_s");
    for (int i = 0; i < 6; i++) begin
      logic [11:0] bd;
      bd = 12'($urandom);
      s = 1'($urandom);
      run_b(bd, s, model({244'd0, bd}, s, MB, WB, RWB), "b_rand");
    end

    for (int i = 0; i < 20; i++) begin
      d = rand_bundle();
      s = 1'($urandom);
      run_a(d, s, model(d, s, MA, WA, RWA), 1'($urandom), int'($urandom_range(0, 3)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/series_adder_bitserial.md
SERIES_ADDER_BITSERIAL -- requirements
Module: series_adder_bitserial

Interface
REQ-001 Parameter M, default 8, meaning number of operand channels; legal range 2..64.
REQ-002 Parameter W, default 32, meaning operand width in bits; legal range 2..64.
REQ-003 Derived localparam L = $clog2(M), meaning flush cycles; RW = W + L, meaning result width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low; synchronous deassert is the integrator's responsibility.
REQ-006 in_valid  input  1  operand bundle valid.
REQ-007 in_ready  output  1  block can accept a bundle.
REQ-008 data_i  input  M*W  packed operands; channel c occupies bits [c*W+W-1 : c*W].
REQ-009 signed_i  input  1  1 = operands two's complement, 0 = unsigned; sampled with the bundle.
REQ-010 plane_o  output  M  current bit-plane; bit c = bit k of channel c.
REQ-011 plane_vld  output  1  plane_o valid this cycle.
REQ-012 plane_last  output  1  plane_o is plane W-1.
REQ-013 result_o  output  RW  sum of the M operands.
REQ-014 result_vld  output  1  result_o valid.
REQ-015 result_rdy  input  1  consumer accepts result.
REQ-016 busy  output  1  high in any state except IDLE.

Function
REQ-017 The block SHALL implement states IDLE, SHIFT, FLUSH and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE; a bundle is accepted on an edge with in_valid=1 and in_ready=1.
REQ-019 On accept, the block SHALL register data_i and signed_i, clear the accumulator and plane counter k, and enter SHIFT.
REQ-020 SHIFT SHALL last exactly W cycles, presenting plane k = 0..W-1 in LSB-first order, one plane per cycle, with plane_vld=1.
REQ-021 plane_last SHALL be 1 only with plane k=W-1.
REQ-022 Each SHIFT cycle, the block SHALL form t = carry + popcount(plane), where carry is a signed register of L+2 bits.
REQ-023 When signed_i=1 and k=W-1, the popcount term SHALL instead be subtracted.
REQ-024 Each SHIFT cycle, the block SHALL write result bit k = t[0] and set carry = t >>> 1 (arithmetic shift).
REQ-025 FLUSH SHALL last exactly L cycles, emitting result bits W..RW-1 from the carry LSB with the same arithmetic shift.
REQ-026 In FLUSH, plane_vld SHALL be 0.
REQ-027 The block SHALL enter DONE after FLUSH, holding result_vld=1 and result_o stable until result_rdy=1.
REQ-028 On that edge, the block SHALL return to IDLE; result_vld SHALL be 0 the next cycle.
REQ-029 Latency SHALL be fixed: result_vld rises on the clock edge W+L+1 cycles after the accept edge (36 for M=8, W=32), independent of data.
REQ-030 The result SHALL be exact with no overflow: unsigned sum in [0, M*(2^W-1)]; signed sum is the RW-bit two's complement value.
REQ-031 in_valid while busy SHALL be ignored and no bundle buffered; data_i and signed_i changes after accept SHALL NOT affect the running sum.
REQ-032 The result_rdy level SHALL be ignored outside DONE.
REQ-033 A pre-asserted result_rdy SHALL give a one-cycle result_vld pulse.
REQ-034 Back-to-back operation SHALL be possible: the next accept occurs no earlier than one cycle after the DONE handshake.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE, with in_ready=1 (after the first edge with rst_n=1 it remains 1), busy=0, plane_vld=0, plane_last=0, result_vld=0, result_o=0, plane_o=0, and counter and carry cleared.
REQ-036 Reset mid-SHIFT, mid-FLUSH or in DONE SHALL discard the operation; no result_vld is produced for it.

Verification
REQ-037 M=8, W=32, unsigned, words 1..8 -> result_o=0x24, result_vld 36 cycles after accept, 32 plane_vld cycles, plane_last on the 32nd.
REQ-038 M=8, W=32, unsigned, all words 0xFFFFFFFF -> result_o=0x7FFFFFFF8.
REQ-039 M=8, W=32, channel0=0xFFFFFFFF, channel1=0x00000003, others 0: signed_i=1 -> result_o=0x2; signed_i=0 -> result_o=0x100000002.
REQ-040 result_rdy held 0 for 10 cycles in DONE, with in_valid held 1 -> result_vld and result_o stable, in_ready=0, no second accept; after result_rdy=1, return to IDLE and accept the second bundle.
REQ-041 rst_n pulsed low at plane k=10 -> all outputs at reset values, no result_vld; a new bundle then yields a correct result.
REQ-042 M=3, W=4, signed, all words 0x8 -> result_o=0x28 (-24 in 6 bits), result_vld 7 cycles after accept.
